// File: rtl/kmul_pkg.sv
// Shared types and constants for the Karatsuba multiply-accumulate slice.
package kmul_pkg;
  localparam int OP_W          = 16;
  localparam int PROD_W        = 32;
  localparam int ACC_W_DEF     = 40;
  localparam int MAX_TERMS_DEF = 256;

  // ST_DRAIN: last beat sits in the stage register; ST_HOLD: result waiting for out_ready
  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_DRAIN,
    ST_HOLD
  } state_t;
endpackage

// File: rtl/kmul_mac_stage_if.sv
// Operand-in / result-out stream bundle for kmul_mac_stage.
interface kmul_mac_stage_if
  import kmul_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_a;
  logic [OP_W-1:0]   in_b;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/kmul16.sv
// Existing combinational 16x16 unsigned Karatsuba multiplier (one split level, 8-bit halves).
module kmul16
  import kmul_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] prod
);
  logic [7:0]  ah, al, bh, bl;
  logic [15:0] z2, z0;
  logic [8:0]  sa, sb;
  logic [17:0] zm, z1;

  assign ah = a[15:8];
  assign al = a[7:0];
  assign bh = b[15:8];
  assign bl = b[7:0];

  assign z2 = {8'b0, ah} * {8'b0, bh};
  assign z0 = {8'b0, al} * {8'b0, bl};
  assign sa = {1'b0, ah} + {1'b0, al};
  assign sb = {1'b0, bh} + {1'b0, bl};
  assign zm = {9'b0, sa} * {9'b0, sb};
  // middle term ah*bl + al*bh recovered from the cross product
  assign z1 = zm - {2'b0, z2} - {2'b0, z0};

  assign prod = {z2, 16'b0} + {6'b0, z1, 8'b0} + {16'b0, z0};
endmodule

// File: rtl/kmul_mac_stage.sv
// Registers operands onto the external multiplier, sums products one cycle later and
// emits dot-product, term count and overflow at packet end.
module kmul_mac_stage
  import kmul_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF,
  parameter int CNT_W     = 9
)(
  input  logic              clk,
  input  logic              rst,
  kmul_mac_stage_if.slave   s,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_prod
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_TERMS - 1);

  state_t           state;
  logic             stage_v;
  logic             stage_last;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic             ovf;

  logic             out_valid_q;
  logic [ACC_W-1:0] out_acc_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_ovf_q;

  logic [ACC_W:0]   sum;
  logic             accept;
  logic             end_term;

  assign sum      = {1'b0, acc} + (ACC_W + 1)'(mul_prod);
  // ST_ACCUM is exactly !out_valid && !(stage_v && stage_last)
  assign s.in_ready = !rst && (state == ST_ACCUM);
  assign accept   = s.in_valid && s.in_ready;
  assign end_term = s.in_last || (idx == LAST_IDX);

  assign s.out_valid = out_valid_q;
  assign s.out_acc   = out_acc_q;
  assign s.out_count = out_count_q;
  assign s.out_ovf   = out_ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ACCUM;
      stage_v     <= 1'b0;
      stage_last  <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      idx         <= '0;
      ovf         <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (stage_v) begin
            acc <= sum[ACC_W-1:0];
            ovf <= ovf | sum[ACC_W];
            cnt <= cnt + CNT_W'(1);
          end
          if (accept) begin
            mul_a      <= s.in_a;
            mul_b      <= s.in_b;
            stage_v    <= 1'b1;
            stage_last <= end_term;
            idx        <= end_term ? '0 : idx + CNT_W'(1);
            if (end_term) state <= ST_DRAIN;
          end else begin
            stage_v <= 1'b0;
          end
        end
        ST_DRAIN: begin
          out_acc_q   <= sum[ACC_W-1:0];
          out_count_q <= cnt + CNT_W'(1);
          out_ovf_q   <= ovf | sum[ACC_W];
          out_valid_q <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
          ovf         <= 1'b0;
          stage_v     <= 1'b0;
          stage_last  <= 1'b0;
          state       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (s.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_ACCUM;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end
endmodule
